// File: rtl/h_sync_gen.sv
// Horizontal timing decoder for the SN7493 pixel counter chain: settles the ripple count, decodes blank/sync/line-end, closes the line via HRESET.
// Optional ripple filter enabled by defining RIPPLE_SETTLE_EN; otherwise HACC tracks the sampled count every edge.
module h_sync_gen #(
    parameter int unsigned HTOTAL       = 455,
    parameter int unsigned HBLANK_START = 320,
    parameter int unsigned HSYNC_START  = 336,
    parameter int unsigned HSYNC_END    = 368,
    parameter int unsigned SETTLE       = 3
) (
    input  logic       CLK_DRV,
    input  logic       RESET_N,
    input  logic [8:0] H,
    output logic       HRESET,
    output logic       HBLANK,
    output logic       HSYNC,
    output logic       LINE_STB,
    output logic [8:0] HACC
);

    localparam int unsigned H_W = 9;

    localparam logic [H_W-1:0] C_BLANK = H_W'(HBLANK_START);
    localparam logic [H_W-1:0] C_SYNC  = H_W'(HSYNC_START);
    localparam logic [H_W-1:0] C_SEND  = H_W'(HSYNC_END);
    localparam logic [H_W-1:0] C_LAST  = H_W'(HTOTAL - 1);

    localparam logic [2:0] S_ACTIVE    = 3'd0;
    localparam logic [2:0] S_BLANK     = 3'd1;
    localparam logic [2:0] S_SYNC      = 3'd2;
    localparam logic [2:0] S_BACKPORCH = 3'd3;
    localparam logic [2:0] S_RESET     = 3'd4;

    if (!((HBLANK_START <= HSYNC_START) && (HSYNC_START < HSYNC_END) &&
          (HSYNC_END < HTOTAL - 1) && (HTOTAL >= 1) && (HTOTAL - 1 < 512) &&
          (SETTLE >= 1) && (SETTLE <= 7))) begin : g_bad_param
        $error("h_sync_gen: illegal timing parameters");
    end

    logic [H_W-1:0] r_h_q;
    logic [2:0]     r_state;
    logic [2:0]     w_state_nxt;
    logic           r_rst_seen;
    logic           w_leave_rst;

    // Raw sample of the ripple counter outputs.
    always_ff @(posedge CLK_DRV or negedge RESET_N) begin
        if (!RESET_N) begin
            r_h_q <= '0;
        end else begin
            r_h_q <= H;
        end
    end

`ifdef RIPPLE_SETTLE_EN
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] C_SAT = CNT_W'(SETTLE);
    // Accept fires on the edge the counter would reach SETTLE-1, giving SETTLE edges of latency.
    localparam logic [CNT_W-1:0] C_ACC = (SETTLE >= 2) ? CNT_W'(SETTLE - 2) : '0;

    logic [CNT_W-1:0] r_stab_cnt;
    logic             w_same;
    logic             w_accept;

    assign w_same   = (H == r_h_q);
    assign w_accept = w_same && (r_stab_cnt == C_ACC);

    always_ff @(posedge CLK_DRV or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stab_cnt <= '0;
        end else if (!w_same) begin
            r_stab_cnt <= '0;
        end else if (r_stab_cnt != C_SAT) begin
            r_stab_cnt <= r_stab_cnt + CNT_W'(1);
        end
    end
`endif

    // Accepted count; cleared when the line restarts so ACTIVE never sees a stale end count.
    always_ff @(posedge CLK_DRV or negedge RESET_N) begin
        if (!RESET_N) begin
            HACC <= '0;
        end else if (w_leave_rst) begin
            HACC <= '0;
        end else begin
`ifdef RIPPLE_SETTLE_EN
            if (w_accept) begin
                HACC <= r_h_q;
            end
`else
            HACC <= r_h_q;
`endif
        end
    end

    always_ff @(posedge CLK_DRV or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_ACTIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACTIVE:    if (HACC >= C_BLANK) w_state_nxt = S_BLANK;
            S_BLANK:     if (HACC >= C_SYNC)  w_state_nxt = S_SYNC;
            S_SYNC:      if (HACC >= C_SEND)  w_state_nxt = S_BACKPORCH;
            S_BACKPORCH: if (HACC >= C_LAST)  w_state_nxt = S_RESET;
            S_RESET:     if (r_rst_seen && (r_h_q == '0)) w_state_nxt = S_ACTIVE;
            default:     w_state_nxt = S_ACTIVE;
        endcase
    end

    assign w_leave_rst = (r_state == S_RESET) && (w_state_nxt == S_ACTIVE);

    // Set after the first full cycle in RESET, enforcing the two-cycle HRESET minimum.
    always_ff @(posedge CLK_DRV or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rst_seen <= 1'b0;
        end else begin
            r_rst_seen <= (r_state == S_RESET);
        end
    end

    always_ff @(posedge CLK_DRV or negedge RESET_N) begin
        if (!RESET_N) begin
            HBLANK   <= 1'b0;
            HSYNC    <= 1'b0;
            HRESET   <= 1'b0;
            LINE_STB <= 1'b0;
        end else begin
            HBLANK   <= (w_state_nxt != S_ACTIVE);
            HSYNC    <= (w_state_nxt == S_SYNC);
            HRESET   <= (w_state_nxt == S_RESET);
            LINE_STB <= (w_state_nxt == S_RESET) && (r_state != S_RESET);
        end
    end

endmodule

// File: tb/tb_h_sync_gen.sv
// Directed self-checking bench for h_sync_gen; expectations follow RIPPLE_SETTLE_EN as the design build does.
module tb_h_sync_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] h;
    logic       hreset, hblank, hsync, line_stb;
    logic [8:0] hacc;

    h_sync_gen dut (
        .CLK_DRV (clk),
        .RESET_N (rst_n),
        .H       (h),
        .HRESET  (hreset),
        .HBLANK  (hblank),
        .HSYNC   (hsync),
        .LINE_STB(line_stb),
        .HACC    (hacc)
    );

    always #5 clk = ~clk;

`ifdef RIPPLE_SETTLE_EN
    localparam int LAT = 3;
    logic [8:0] exp_f [0:5] = '{9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h100, 9'h100};
`else
    localparam int LAT = 2;
    logic [8:0] exp_f [0:5] = '{9'h0FF, 9'h0FE, 9'h0FC, 9'h100, 9'h100, 9'h100};
`endif

    int n_cmp = 0;
    int n_err = 0;

    int blank_acc  = -1;
    int sync_rise  = -1;
    int sync_fall  = -1;
    int sync_ticks = 0;
    int stb_cnt    = 0;
    int stb_acc    = -1;
    int stb_hrst   = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_track();
        logic pb, ps;
        pb = hblank;
        ps = hsync;
        tick();
        if (hblank && !pb && blank_acc < 0) blank_acc = int'(hacc);
        if (hsync && !ps) sync_rise = int'(hacc);
        if (!hsync && ps) sync_fall = int'(hacc);
        if (hsync) sync_ticks++;
        if (line_stb) begin
            stb_cnt++;
            stb_acc  = int'(hacc);
            stb_hrst = int'(hreset);
        end
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        h     = 9'd0;
        repeat (3) tick();
        chk("rst_hacc",   32'(hacc),     32'd0);
        chk("rst_hblank", 32'(hblank),   32'd0);
        chk("rst_hsync",  32'(hsync),    32'd0);
        chk("rst_hreset", 32'(hreset),   32'd0);
        chk("rst_stb",    32'(line_stb), 32'd0);
        rst_n = 1'b1;

        // Ripple filter: 0x0FF -> 0x0FE -> 0x0FC -> 0x100
        h = 9'h0FF;
        repeat (6) tick();
        chk("flt_base", 32'(hacc), 32'h0FF);
        for (int i = 0; i < 6; i++) begin
            h = (i == 0) ? 9'h0FE : (i == 1) ? 9'h0FC : 9'h100;
            tick();
            chk($sformatf("flt_t%0d", i + 1), 32'(hacc), 32'(exp_f[i]));
        end
        chk("flt_hblank", 32'(hblank), 32'd0);

        // Full line from a clean reset
        rst_n = 1'b0;
        h     = 9'd0;
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 454; c++) begin
            h = 9'(c);
            repeat (8) tick_track();
        end
        h    = 9'd454;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick_track();
            if (hreset) seen = 1'b1;
        end
        chk("hreset_seen", 32'(seen), 32'd1);
        chk("blank_rise_acc", 32'(blank_acc), 32'd320);
        chk("sync_rise_acc",  32'(sync_rise), 32'd336);
        chk("sync_fall_acc",  32'(sync_fall), 32'd368);
        chk("sync_ticks",     32'(sync_ticks), 32'd256);
        chk("stb_acc",        32'(stb_acc),   32'd454);
        chk("stb_hreset",     32'(stb_hrst),  32'd1);

        // HRESET handshake
        for (int i = 0; i < 5; i++) begin
            tick_track();
            chk($sformatf("hrst_hold%0d", i), 32'(hreset), 32'd1);
        end
        h = 9'd0;
        tick_track();
        chk("hrst_q_pend",   32'(hreset), 32'd1);
        chk("hblank_q_pend", 32'(hblank), 32'd1);
        tick_track();
        chk("hrst_release",  32'(hreset), 32'd0);
        chk("hblank_release", 32'(hblank), 32'd0);
        chk("hacc_cleared",  32'(hacc),   32'd0);
        chk("stb_once",      32'(stb_cnt), 32'd1);

        // Skip 300 -> 340: BLANK then SYNC on consecutive edges
        h = 9'd300;
        repeat (6) tick();
        chk("skip_base", 32'(hacc), 32'd300);
        h = 9'd340;
        repeat (LAT) tick();
        chk("skip_hacc",    32'(hacc),   32'd340);
        chk("skip_blank0",  32'(hblank), 32'd0);
        tick();
        chk("skip_blank1",  32'(hblank), 32'd1);
        chk("skip_sync1",   32'(hsync),  32'd0);
        tick();
        chk("skip_sync2",   32'(hsync),  32'd1);

        // Asynchronous reset mid-SYNC
        rst_n = 1'b0;
        #2;
        chk("mid_hacc",   32'(hacc),     32'd0);
        chk("mid_hsync",  32'(hsync),    32'd0);
        chk("mid_hblank", 32'(hblank),   32'd0);
        chk("mid_hreset", 32'(hreset),   32'd0);
        chk("mid_stb",    32'(line_stb), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mid_post_blank", 32'(hblank), 32'd0);
        chk("mid_post_sync",  32'(hsync),  32'd0);
        repeat (LAT - 1) tick();
        chk("mid_resume_hacc",  32'(hacc),   32'd340);
        tick();
        chk("mid_resume_blank", 32'(hblank), 32'd1);
        tick();
        chk("mid_resume_sync",  32'(hsync),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
